adder_rr_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one four_bit_adder among NREQ requesters.

---
 rtl/adder_rr_arbiter_pkg.sv | 16 +
 rtl/adder_rr_arbiter_rr_pick.sv | 41 ++++
 rtl/four_bit_adder.sv | 14 +
 rtl/adder_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_adder_rr_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_rr_arbiter_pkg.sv
// Shared definitions for the adder round-robin arbiter: FSM state encoding and adder width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_rr_arbiter_pkg;

    // Width of the shared four_bit_adder datapath.
    localparam int ADD_WIDTH = 4;

    // Sequencer states. One operation takes IDLE -> GRANT -> DONE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Round-robin priority pick: first asserted req at or after ptr, wrapping NREQ-1 -> 0.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req request vector, ptr search start; onehot/idx winner, any = some req set.
module rr_pick
    import adder_rr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        cand   = 0;
        any    = |req;
        // Walk from the farthest candidate back toward ptr so the closest
        // asserted request (in rotation order) is the last one written.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (req[cand]) begin
                idx = IDW'(cand);
            end
        end
        if (any) begin
            onehot = NREQ'(1) << idx;
        end
    end

endmodule

// File: rtl/four_bit_adder.sv
// Shared 4-bit ripple adder: Sum/Couts = A + B.
// Latency: combinational.
// Backpressure: none.
// Ports: A, B operands; Sum 4-bit result; Couts carry out.
module four_bit_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Sum,
    output logic       Couts
);

    assign {Couts, Sum} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin sequencer sharing one four_bit_adder among NREQ requesters; registers sum/carry.
// Latency: req in IDLE cycle N -> gnt in N+1 -> done/result in N+2; one op per 3 cycles.
// Backpressure: req is a level held until done; operands sampled only at grant.
// Ports: clk/rst (async active-high); req, op_a, op_b from requesters (WIDTH-bit slots);
//   add_a/add_b/add_sum/add_cout to the external adder; gnt/done one-hot per requester;
//   result/result_cout/result_id hold the last completed op; busy = not IDLE.
module adder_rr_arbiter
    import adder_rr_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = ADD_WIDTH,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      result,
    output logic                  result_cout,
    output logic [IDW-1:0]        result_id,
    output logic                  busy
);

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr, ptr_nxt;
    logic [IDW-1:0]   id_q, id_nxt;
    logic [NREQ-1:0]  gnt_nxt, done_nxt;
    logic [WIDTH-1:0] add_a_nxt, add_b_nxt, result_nxt;
    logic             result_cout_nxt;
    logic [IDW-1:0]   result_id_nxt;

    logic [NREQ-1:0]  win_oh;
    logic [IDW-1:0]   win_idx;
    logic             win_any;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (win_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            id_q        <= '0;
            gnt         <= '0;
            done        <= '0;
            add_a       <= '0;
            add_b       <= '0;
            result      <= '0;
            result_cout <= 1'b0;
            result_id   <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            id_q        <= id_nxt;
            gnt         <= gnt_nxt;
            done        <= done_nxt;
            add_a       <= add_a_nxt;
            add_b       <= add_b_nxt;
            result      <= result_nxt;
            result_cout <= result_cout_nxt;
            result_id   <= result_id_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        id_nxt          = id_q;
        gnt_nxt         = gnt;
        done_nxt        = '0;       // done is a single-cycle pulse
        add_a_nxt       = add_a;    // adder operands hold outside GRANT
        add_b_nxt       = add_b;
        result_nxt      = result;
        result_cout_nxt = result_cout;
        result_id_nxt   = result_id;

        case (state)
            ST_IDLE: begin
                if (win_any) begin
                    gnt_nxt   = win_oh;
                    add_a_nxt = op_a[int'(win_idx)*WIDTH +: WIDTH];
                    add_b_nxt = op_b[int'(win_idx)*WIDTH +: WIDTH];
                    id_nxt    = win_idx;
                    // Pointer advances only on a grant, to just past the winner.
                    ptr_nxt   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // The operation completes even if req dropped meanwhile.
                result_nxt      = add_sum;
                result_cout_nxt = add_cout;
                result_id_nxt   = id_q;
                done_nxt        = NREQ'(1) << id_q;
                gnt_nxt         = '0;
                state_nxt       = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter with the real four_bit_adder on the add_* ports.
// Latency: n/a.
// Backpressure: n/a.
module tb_adder_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0]      add_a, add_b, add_sum;
    logic                  add_cout;
    logic [NREQ-1:0]       gnt, done;
    logic [WIDTH-1:0]      result;
    logic                  result_cout;
    logic [IDW-1:0]        result_id;
    logic                  busy;

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;   // reference model round-robin pointer

    adder_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .op_a        (op_a),
        .op_b        (op_b),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_sum     (add_sum),
        .add_cout    (add_cout),
        .gnt         (gnt),
        .done        (done),
        .result      (result),
        .result_cout (result_cout),
        .result_id   (result_id),
        .busy        (busy)
    );

    four_bit_adder u_add (
        .A     (add_a),
        .B     (add_b),
        .Sum   (add_sum),
        .Couts (add_cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_gnt;
        logic [3:0] exp_sum;
        logic       exp_cout;
        logic [1:0] exp_id;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " gnt"}, 32'(gnt), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " add_a"}, 32'(add_a), 0);
        chk({tag, " add_b"}, 32'(add_b), 0);
        chk({tag, " result"}, 32'(result), 0);
        chk({tag, " result_cout"}, 32'(result_cout), 0);
        chk({tag, " result_id"}, 32'(result_id), 0);
        chk({tag, " busy"}, 32'(busy), 0);
    endtask

    // Reference: first requester at or after the pointer, rotating.
    function automatic int rr_winner(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Full transaction from an IDLE cycle: grant next cycle, done/result the one after.
    task automatic run_op(input string tag, input logic [3:0] r,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] eg, input logic [3:0] es,
                          input logic ec, input logic [1:0] eid);
        req  = r;
        op_a = a;
        op_b = b;
        chk({tag, " idle busy"}, 32'(busy), 0);
        step();
        chk({tag, " gnt"}, 32'(gnt), 32'(eg));
        chk({tag, " busy"}, 32'(busy), 1);
        chk({tag, " early done"}, 32'(done), 0);
        step();
        chk({tag, " done"}, 32'(done), 32'(eg));
        chk({tag, " result"}, 32'(result), 32'(es));
        chk({tag, " cout"}, 32'(result_cout), 32'(ec));
        chk({tag, " id"}, 32'(result_id), 32'(eid));
        chk({tag, " gnt off"}, 32'(gnt), 0);
        req = '0;
        step();
        chk({tag, " done pulse"}, 32'(done), 0);
        mptr = (int'(eid) + 1) % NREQ;
    endtask

    vec_t vecs[5];

    initial begin
        logic [15:0] a, b;
        logic [4:0]  s;
        logic [3:0]  r;
        int          w;

        vecs[0] = '{4'b0001, 4'h3, 4'h4, 4'b0001, 4'h7, 1'b0, 2'd0};
        vecs[1] = '{4'b0100, 4'hF, 4'h1, 4'b0100, 4'h0, 1'b1, 2'd2};
        vecs[2] = '{4'b1000, 4'h8, 4'h8, 4'b1000, 4'h0, 1'b1, 2'd3};
        vecs[3] = '{4'b0010, 4'h5, 4'hA, 4'b0010, 4'hF, 1'b0, 2'd1};
        vecs[4] = '{4'b0001, 4'hF, 4'hF, 4'b0001, 4'hE, 1'b1, 2'd0};

        rst  = 1'b1;
        req  = '0;
        op_a = '0;
        op_b = '0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        step();

        // Single-requester vectors; other slots carry unrelated operands.
        foreach (vecs[i]) begin
            a = 16'($urandom);
            b = 16'($urandom);
            a[int'(vecs[i].exp_id)*4 +: 4] = vecs[i].a;
            b[int'(vecs[i].exp_id)*4 +: 4] = vecs[i].b;
            run_op($sformatf("vec%0d", i), vecs[i].r, a, b, vecs[i].exp_gnt,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_id);
        end

        // Operand change during GRANT is ignored.
        req  = 4'b0010;
        op_a = 16'h0020;
        op_b = 16'h0020;
        step();
        chk("late_op gnt", 32'(gnt), 32'b0010);
        op_a[7:4] = 4'h9;
        #3;
        chk("late_op add_a held", 32'(add_a), 2);
        step();
        chk("late_op result", 32'(result), 4);
        chk("late_op done", 32'(done), 32'b0010);
        req = '0;
        step();
        mptr = 2;

        // req dropped during GRANT still completes.
        req  = 4'b0100;
        op_a = 16'h0600;
        op_b = 16'h0700;
        step();
        chk("drop gnt", 32'(gnt), 32'b0100);
        req = '0;
        step();
        chk("drop done", 32'(done), 32'b0100);
        chk("drop result", 32'(result), 32'hD);
        step();
        chk("drop done pulse", 32'(done), 0);
        step();
        step();
        chk("idle busy", 32'(busy), 0);
        chk("idle gnt", 32'(gnt), 0);
        mptr = 3;

        // Random request patterns against the reference pointer model.
        for (int n = 0; n < 40; n++) begin
            r = 4'($urandom_range(0, 15));
            a = 16'($urandom);
            b = 16'($urandom);
            if (r == 4'b0) begin
                req = '0;
                step();
                chk("rnd none gnt", 32'(gnt), 0);
                chk("rnd none busy", 32'(busy), 0);
            end else begin
                w = rr_winner(r, mptr);
                s = {1'b0, a[w*4 +: 4]} + {1'b0, b[w*4 +: 4]};
                run_op($sformatf("rnd%0d", n), r, a, b, 4'(1 << w), s[3:0], s[4], 2'(w));
            end
        end

        // Reset during GRANT: outputs clear at once, no done, pointer back to 0.
        req  = 4'b0001;
        op_a = 16'h0005;
        op_b = 16'h0005;
        step();
        chk("rstg gnt", 32'(gnt), 32'b0001);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        req = '0;
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("rstg no done", 32'(done), 0);
        step();
        chk("rstg no done2", 32'(done), 0);
        mptr = 0;
        run_op("post_rst", 4'b1001, 16'h2001, 16'h2001, 4'b0001, 4'h2, 1'b0, 2'd0);

        // All requesters held: strict rotation from pointer 0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i*4 +: 4] = 4'(i + 1);
            op_b[i*4 +: 4] = 4'(4 * i + 3);
        end
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            w = n % NREQ;
            s = 5'(w + 1) + 5'(4 * w + 3);
            step();
            chk($sformatf("rot%0d gnt", n), 32'(gnt), 32'(1 << w));
            step();
            chk($sformatf("rot%0d done", n), 32'(done), 32'(1 << w));
            chk($sformatf("rot%0d result", n), 32'(result), 32'(s[3:0]));
            chk($sformatf("rot%0d cout", n), 32'(result_cout), 32'(s[4]));
            chk($sformatf("rot%0d id", n), 32'(result_id), 32'(w));
            step();
        end
        req = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
